// File: rtl/mem_stage_hs_pkg.sv
// Shared types and encodings for the handshaked memory stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Encoding 2'b11 is accepted as a full-width access.
  function automatic logic sz_is_word(logic [1:0] size);
    return (size == SZ_WORD) || (size == 2'b11);
  endfunction

endpackage

// File: rtl/mem_stage_hs_if.sv
// Execute-side and memory-side signal bundle of the memory stage.
interface mem_stage_hs_if #(
  parameter int unsigned N    = 32,
  parameter int unsigned RD_W = 4
);
  // Upstream (execute) side
  logic            in_valid;
  logic            mem_read;
  logic            mem_write;
  logic            pix_sel;
  logic [1:0]      size;
  logic            sign_ext;
  logic [N-1:0]    address;
  logic [N-1:0]    write_data;
  logic [RD_W-1:0] rd_in;
  logic            stall;
  // Downstream (MEM/WB) side
  logic            out_valid;
  logic [N-1:0]    read_data;
  logic [N-1:0]    alu_result_out;
  logic [RD_W-1:0] rd_out;
  logic            misalign;
  logic            timeout;
  // Memory port
  logic            mem_req;
  logic            mem_we;
  logic            mem_pix;
  logic [N-1:0]    mem_addr;
  logic [N-1:0]    mem_wdata;
  logic [N/8-1:0]  mem_be;
  logic [N-1:0]    mem_rdata;
  logic            mem_ack;

  // Environment: execute stage, MEM/WB register and memories.
  modport master (
    output in_valid, mem_read, mem_write, pix_sel, size, sign_ext, address, write_data, rd_in,
    output mem_rdata, mem_ack,
    input  stall, out_valid, read_data, alu_result_out, rd_out, misalign, timeout,
    input  mem_req, mem_we, mem_pix, mem_addr, mem_wdata, mem_be
  );

  // The memory stage itself.
  modport slave (
    input  in_valid, mem_read, mem_write, pix_sel, size, sign_ext, address, write_data, rd_in,
    input  mem_rdata, mem_ack,
    output stall, out_valid, read_data, alu_result_out, rd_out, misalign, timeout,
    output mem_req, mem_we, mem_pix, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_stage_hs_lane_align.sv
// Byte-lane enables, store-data replication and load extract/extend.
module mem_stage_hs_lane_align
  import mem_stage_pkg::*;
#(
  parameter int unsigned N    = 32,
  parameter int unsigned OffW = 2
) (
  input  logic [1:0]      i_size,
  input  logic [OffW-1:0] i_off,
  input  logic            i_sign_ext,
  input  logic [N-1:0]    i_wdata,
  input  logic [N-1:0]    i_rdata,
  output logic [N/8-1:0]  o_be,
  output logic [N-1:0]    o_wdata,
  output logic [N-1:0]    o_rdata
);
  localparam int unsigned BeW = N / 8;

  logic [N-1:0] w_shift;

  // Move the addressed lane(s) down to bit 0.
  assign w_shift = i_rdata >> {i_off, 3'b000};

  // Decode lanes and build replicated store data / extended load data.
  always_comb begin
    o_be    = '1;
    o_wdata = i_wdata;
    o_rdata = w_shift;
    case (i_size)
      SZ_BYTE: begin
        o_be    = BeW'(1) << i_off;
        o_wdata = {BeW{i_wdata[7:0]}};
        o_rdata = {{(N - 8){i_sign_ext & w_shift[7]}}, w_shift[7:0]};
      end
      SZ_HALF: begin
        o_be    = BeW'(3) << i_off;
        o_wdata = {(N / 16){i_wdata[15:0]}};
        o_rdata = {{(N - 16){i_sign_ext & w_shift[15]}}, w_shift[15:0]};
      end
      default: begin
        // Word accesses are aligned, so the shift is zero and data passes through.
        o_be    = '1;
        o_wdata = i_wdata;
        o_rdata = w_shift;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// Pipelined memory stage: registers execute results toward MEM/WB and runs
// one req/ack memory access at a time, stalling execute while it is pending.
module mem_stage_hs
  import mem_stage_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned RD_W    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst,
  mem_stage_hs_if.slave bus
);
  localparam int unsigned BeW  = N / 8;
  localparam int unsigned OffW = $clog2(BeW);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_cnt;
  logic            r_out_valid, r_misalign, r_timeout;
  logic [N-1:0]    r_read_data, r_alu_result;
  logic [RD_W-1:0] r_rd;
  logic            r_mem_req, r_mem_we, r_mem_pix;
  logic [N-1:0]    r_mem_addr, r_mem_wdata;
  logic [BeW-1:0]  r_mem_be;
  logic [1:0]      r_size;
  logic [OffW-1:0] r_off;
  logic            r_sign_ext, r_load;

  logic [OffW-1:0] w_off, w_la_off;
  logic [1:0]      w_la_size;
  logic            w_is_mem, w_misalign, w_accept, w_start, w_ack, w_timeout;
  logic [BeW-1:0]  w_be;
  logic [N-1:0]    w_wdata, w_rdata_ext;

  assign w_off      = bus.address[OffW-1:0];
  assign w_is_mem   = bus.mem_read | bus.mem_write;
  assign w_misalign = ((bus.size == SZ_HALF) && bus.address[0]) ||
                      (sz_is_word(bus.size) && (w_off != '0));
  // DONE accepts like IDLE so back-to-back ops lose no cycle.
  assign w_accept   = bus.in_valid && (r_state != StReq);
  assign w_start    = w_accept && w_is_mem && !w_misalign;
  assign w_ack      = (r_state == StReq) && bus.mem_ack;
  assign w_timeout  = (r_state == StReq) && !bus.mem_ack && (r_cnt == CntW'(TIMEOUT - 1));

  // Lane logic sees the live op at accept and the latched op while waiting for ack.
  assign w_la_size  = (r_state == StReq) ? r_size : bus.size;
  assign w_la_off   = (r_state == StReq) ? r_off : w_off;

  mem_stage_hs_lane_align #(
    .N    (N),
    .OffW (OffW)
  ) u_lane_align (
    .i_size     (w_la_size),
    .i_off      (w_la_off),
    .i_sign_ext (r_sign_ext),
    .i_wdata    (bus.write_data),
    .i_rdata    (bus.mem_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata_ext)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle, StDone: w_state_next = w_start ? StReq : StIdle;
      StReq:          if (w_ack || w_timeout) w_state_next = StDone;
      default:        w_state_next = StIdle;
    endcase
  end

  // Output fields, memory request and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_misalign   <= 1'b0;
      r_timeout    <= 1'b0;
      r_read_data  <= '0;
      r_alu_result <= '0;
      r_rd         <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_pix    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= '0;
      r_size       <= '0;
      r_off        <= '0;
      r_sign_ext   <= 1'b0;
      r_load       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        r_alu_result <= bus.address;
        r_rd         <= bus.rd_in;
        r_read_data  <= '0;
        r_misalign   <= w_is_mem & w_misalign;
        r_timeout    <= 1'b0;
        r_out_valid  <= !w_start;
        if (w_start) begin
          r_mem_req   <= 1'b1;
          r_mem_we    <= !bus.mem_read;  // load wins when both are set
          r_mem_pix   <= bus.pix_sel;
          r_mem_addr  <= {bus.address[N-1:OffW], {OffW{1'b0}}};
          r_mem_wdata <= w_wdata;
          r_mem_be    <= w_be;
          r_size      <= bus.size;
          r_off       <= w_off;
          r_sign_ext  <= bus.sign_ext;
          r_load      <= bus.mem_read;
          r_cnt       <= '0;
        end
      end
      if (r_state == StReq) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_ack) begin
          r_mem_req   <= 1'b0;
          r_out_valid <= 1'b1;
          if (r_load) r_read_data <= w_rdata_ext;
        end else if (w_timeout) begin
          r_mem_req   <= 1'b0;
          r_out_valid <= 1'b1;
          r_timeout   <= 1'b1;
        end
      end
    end
  end

  assign bus.stall          = (r_state == StReq);
  assign bus.out_valid      = r_out_valid;
  assign bus.read_data      = r_read_data;
  assign bus.alu_result_out = r_alu_result;
  assign bus.rd_out         = r_rd;
  assign bus.misalign       = r_misalign;
  assign bus.timeout        = r_timeout;
  assign bus.mem_req        = r_mem_req;
  assign bus.mem_we         = r_mem_we;
  assign bus.mem_pix        = r_mem_pix;
  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_wdata      = r_mem_wdata;
  assign bus.mem_be         = r_mem_be;

endmodule

// File: doc/mem_stage_hs.md
# mem_stage_hs

Pipelined, handshaked memory stage sitting between the execute stage and the MEM/WB register of the hybrid ARM/MIPS core. It accepts one operation per cycle from execute and registers it into a MEM/WB-facing output. Loads and stores are routed to either the data memory or the pixel memory through an external req/ack port with arbitrary wait states, using byte-lane enables for byte/half/word accesses. The execute stage is stalled until each memory access completes.

## Interface
Parameters:
- N, 32, datapath width; multiple of 16; word access = N bits
- RD_W, 4, destination register index width
- TIMEOUT, 64, max cycles waiting for mem_ack before abort

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  execute stage presents an operation
- mem_read  in  1  operation is a load
- mem_write  in  1  operation is a store (mem_read and mem_write both set = load wins)
- pix_sel  in  1  0 = data memory, 1 = pixel memory
- size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- sign_ext  in  1  sign-extend narrow loads
- address  in  N  ALU result / memory address
- write_data  in  N  store data, right-aligned
- rd_in  in  RD_W  destination register
- stall  out  1  upstream must hold inputs and in_valid
- out_valid  out  1  output fields valid this cycle
- read_data  out  N  extended load result (0 for non-loads)
- alu_result_out  out  N  registered address
- rd_out  out  RD_W  registered destination
- misalign  out  1  op dropped: unaligned address
- timeout  out  1  op aborted: no mem_ack within TIMEOUT
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  request is a write
- mem_pix  out  1  target is pixel memory
- mem_addr  out  N  word-aligned address (low log2(N/8) bits zeroed)
- mem_wdata  out  N  write data replicated across lanes
- mem_be  out  N/8  byte-lane enables
- mem_rdata  in  N  read data, valid in the mem_ack cycle
- mem_ack  in  1  completes request; one cycle

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE, in_valid, no memory op: register fields; out_valid=1 next cycle; stay IDLE.
- IDLE, in_valid, memory op, aligned: latch fields; go REQ; stall=1 from next cycle.
- Same with misaligned address (half with addr[0]=1; word with nonzero low log2(N/8) bits): no request; out_valid=1 and misalign=1 next cycle; read_data=0.
- REQ: mem_req=1, all mem_* outputs stable; counter increments. On mem_ack: capture mem_rdata; go DONE. At count == TIMEOUT-1 without ack: drop mem_req; go DONE with timeout=1, read_data=0.
- DONE: out_valid=1 for one cycle; stall=0; go IDLE. The next operation can be accepted in this cycle.
- Lanes: off = address[log2(N/8)-1:0]. Byte: be = 1<<off. Half: be = 3<<off. Word: all ones. Byte data replicated N/8 times; half data replicated N/16 times.
- Load extraction: the selected lane(s) are shifted to bit 0, then zero- or sign-extended per sign_ext. Word loads pass through.
- Stores: read_data=0.
- stall = (state==REQ).
- rst: state IDLE. Counter and every output reset to 0, including mem_req. A reset in REQ abandons the access.

## Timing
- Non-memory op: 1 cycle latency; throughput 1/cycle.
- Memory op: latency = 2 + W cycles, where W = cycles from first mem_req to mem_ack (W=0 if ack is in the first req cycle). stall is high for W+1 cycles.
- Ack arriving in the same cycle as the timeout limit counts as success.
- mem_ack outside REQ is ignored.

## Structure
- Package mem_stage_pkg: state enum (IDLE, REQ, DONE), size encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
- Sub-module lane_align: combinational byte-enable/replication and load extract/extend from (size, off, sign_ext, data).
- Data and pixel memories stay outside; a top-level glue decodes mem_pix to them.

## Test plan
- ALU op: in_valid, address=0x1234, rd_in=5 -> next cycle out_valid=1, alu_result_out=0x1234, rd_out=5, stall=0.
- Store byte: addr=0x103, data=0xAB -> mem_be=4'b1000, mem_addr=0x100, mem_wdata=0xABABABAB, mem_we=1. With ack after 3 cycles -> out_valid 5 cycles after accept.
- Load half, sign_ext=1: addr=0x2, mem_rdata=0x8001_0000, pix_sel=1 -> mem_pix=1, read_data=0xFFFF8001. With sign_ext=0 -> 0x00008001.
- Misaligned word load: addr=0x6 -> no mem_req; next cycle out_valid=1, misalign=1, read_data=0.
- No ack -> mem_req high for exactly TIMEOUT cycles, then out_valid=1, timeout=1.
- rst asserted while in REQ -> mem_req=0, stall=0, out_valid=0 the next cycle; the next op is accepted normally.
